// File: rtl/coprocessor0_scalable_pkg.sv
// coprocessor0_params: shared definitions for the scalable CP0.
//   - CP0 register numbers and the select value that maps them
//   - ExcCode enumeration
//   - packed views of the writable Status/Cause state and helpers that
//     assemble the architectural 32-bit words (constant bits filled in)
package coprocessor0_params;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID     = 5'd15;
    localparam logic [2:0] CP0_SEL_0        = 3'd0;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_IBE  = 5'd6,
        EXC_DBE  = 5'd7,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13
    } exc_code_e;

    // Stateful Status bits; BEV is a constant 1 and lives only in status_word.
    typedef struct packed {
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_data_t;

    // Stateful Cause bits except IP[7:2] and TI, which come from other blocks.
    typedef struct packed {
        logic       bd;
        logic       dc;
        logic [1:0] ip_sw;
        logic [4:0] exc_code;
    } cause_data_t;

    function automatic logic [31:0] status_word(input status_data_t s);
        return {9'd0, 1'b1, 6'd0, s.im, 6'd0, s.exl, s.ie};
    endfunction

    function automatic logic [31:0] cause_word(input cause_data_t c, input logic [5:0] ip_hw,
                                               input logic ti);
        return {c.bd, ti, 2'b00, c.dc, 11'd0, ip_hw, c.ip_sw, 1'b0, c.exc_code, 2'b00};
    endfunction

endpackage

// File: rtl/coprocessor0_scalable_if.sv
// coprocessor0_scalable_if: WB-stage commit bus between the pipeline (master)
// and CP0 (slave).
//   master drives: mtc0 write (write_enabled/address_register/address_select/
//                  write_data), exception commit fields, eret_flush and the
//                  raw hardware_interrupt lines
//   slave drives:  read_data (combinational mfc0), epc_out, interrupt_valid,
//                  timer_interrupt
interface coprocessor0_scalable_if #(
    parameter int HW_INT_COUNT = 6
);
    logic                    write_enabled;
    logic [4:0]              address_register;
    logic [2:0]              address_select;
    logic [31:0]             write_data;
    logic                    exception_valid;
    logic [4:0]              exception_code;
    logic                    is_address_fault;
    logic [31:0]             badvaddr_in;
    logic [31:0]             exception_address;
    logic                    in_delay_slot;
    logic                    eret_flush;
    logic [HW_INT_COUNT-1:0] hardware_interrupt;
    logic [31:0]             read_data;
    logic [31:0]             epc_out;
    logic                    interrupt_valid;
    logic                    timer_interrupt;

    modport master (
        output write_enabled, address_register, address_select, write_data,
               exception_valid, exception_code, is_address_fault, badvaddr_in,
               exception_address, in_delay_slot, eret_flush, hardware_interrupt,
        input  read_data, epc_out, interrupt_valid, timer_interrupt
    );

    modport slave (
        input  write_enabled, address_register, address_select, write_data,
               exception_valid, exception_code, is_address_fault, badvaddr_in,
               exception_address, in_delay_slot, eret_flush, hardware_interrupt,
        output read_data, epc_out, interrupt_valid, timer_interrupt
    );
endinterface

// File: rtl/coprocessor0_scalable_count_timer.sv
// cp0_count_timer: Count prescaler, Count, Compare and the Cause.TI flag.
//   clock, reset     rising-edge clock, async active-high reset
//   dc               Cause.DC: freezes prescaler and Count
//   count_write      mtc0 Count this cycle (loads data, clears prescaler)
//   compare_write    mtc0 Compare this cycle (loads data, clears TI)
//   write_data       mtc0 data
//   count, compare   current register values
//   ti               timer interrupt flag, set on the increment that hits Compare
module cp0_count_timer #(
    parameter int COUNT_DIVIDE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dc,
    input  logic        count_write,
    input  logic        compare_write,
    input  logic [31:0] write_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    // A divide of 1 still keeps a 1-bit prescaler pinned at 0 so the wrap test is uniform.
    localparam int              PRE_W    = (COUNT_DIVIDE > 1) ? $clog2(COUNT_DIVIDE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(COUNT_DIVIDE - 1);

    logic [PRE_W-1:0] prescale_r;
    logic [31:0]      count_r;
    logic [31:0]      compare_r;
    logic             ti_r;
    logic             tick_s;
    logic [31:0]      count_inc_s;

    // Increment strobe: prescaler at its last value and counting enabled.
    always_comb begin
        count_inc_s = count_r + 32'd1;
        if (!dc && (prescale_r == PRE_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Prescaler and Count; a Count write overrides a coincident increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescale_r <= '0;
            count_r    <= 32'd0;
        end else if (count_write) begin
            prescale_r <= '0;
            count_r    <= write_data;
        end else if (!dc) begin
            prescale_r <= (prescale_r == PRE_LAST) ? '0 : prescale_r + PRE_W'(1);
            if (tick_s) begin
                count_r <= count_inc_s;
            end
        end
    end

    // Compare register and TI: edge-triggered set on the matching increment, write-clear wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            compare_r <= 32'd0;
            ti_r      <= 1'b0;
        end else begin
            if (compare_write) begin
                compare_r <= write_data;
                ti_r      <= 1'b0;
            end else if (tick_s && !count_write && (count_inc_s == compare_r)) begin
                ti_r <= 1'b1;
            end
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign ti      = ti_r;
endmodule

// File: rtl/coprocessor0_scalable.sv
// coprocessor0_scalable: MIPS CP0 written back from WB.
//   clock, reset  rising-edge clock, async active-high reset
//   bus           coprocessor0_scalable_if.slave: mtc0/exception/eret commit,
//                 hardware_interrupt lines in; read_data, epc_out,
//                 interrupt_valid, timer_interrupt out
// Holds BadVAddr, Count, Compare, Status, Cause, EPC and a constant PRId.
module coprocessor0_scalable
    import coprocessor0_params::*;
#(
    parameter int          HW_INT_COUNT   = 6,
    parameter int          COUNT_DIVIDE   = 2,
    parameter int          SYNC_STAGES    = 2,
    parameter int          TIMER_IRQ_LINE = 5,
    parameter logic [31:0] PRID_VALUE     = 32'h00004220
) (
    input  logic                   clock,
    input  logic                   reset,
    coprocessor0_scalable_if.slave bus
);
    logic         sel0_s, wr_count_s, wr_compare_s, wr_status_s, wr_cause_s, wr_epc_s;
    logic [31:0]  badvaddr_r, epc_r, count_s, compare_s, read_data_s;
    status_data_t status_r;
    cause_data_t  cause_r;
    logic [5:0]   ip_hw_r, hw_sync_s, hw_irq_s;
    logic         ti_s, int_valid_r;

    // Register-write decode; only select 0 is mapped.
    always_comb begin
        sel0_s       = (bus.address_select == CP0_SEL_0);
        wr_count_s   = bus.write_enabled & sel0_s & (bus.address_register == CP0_REG_COUNT);
        wr_compare_s = bus.write_enabled & sel0_s & (bus.address_register == CP0_REG_COMPARE);
        wr_status_s  = bus.write_enabled & sel0_s & (bus.address_register == CP0_REG_STATUS);
        wr_cause_s   = bus.write_enabled & sel0_s & (bus.address_register == CP0_REG_CAUSE);
        wr_epc_s     = bus.write_enabled & sel0_s & (bus.address_register == CP0_REG_EPC);
    end

    cp0_count_timer #(.COUNT_DIVIDE(COUNT_DIVIDE)) u_count_timer (
        .clock         (clock),
        .reset         (reset),
        .dc            (cause_r.dc),
        .count_write   (wr_count_s),
        .compare_write (wr_compare_s),
        .write_data    (bus.write_data),
        .count         (count_s),
        .compare       (compare_s),
        .ti            (ti_s)
    );

    // Per-line synchronisers; lines beyond HW_INT_COUNT read 0.
    for (genvar gi = 0; gi < 6; gi++) begin : g_sync
        if (gi < HW_INT_COUNT) begin : g_used
            logic [SYNC_STAGES-1:0] stage_r;
            // Shift the asynchronous level through SYNC_STAGES flops.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    stage_r <= '0;
                end else begin
                    stage_r <= {stage_r[SYNC_STAGES-2:0], bus.hardware_interrupt[gi]};
                end
            end
            assign hw_sync_s[gi] = stage_r[SYNC_STAGES-1];
        end else begin : g_unused
            assign hw_sync_s[gi] = 1'b0;
        end
    end

    // Timer flag merged onto its hardware line before IP is registered.
    always_comb begin
        hw_irq_s                 = hw_sync_s;
        hw_irq_s[TIMER_IRQ_LINE] = hw_sync_s[TIMER_IRQ_LINE] | ti_s;
    end

    // Status: exception sets EXL, eret clears it, mtc0 has lowest priority on EXL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_r <= '0;
        end else begin
            if (wr_status_s) begin
                status_r.im <= bus.write_data[15:8];
                status_r.ie <= bus.write_data[0];
            end
            if (bus.exception_valid) begin
                status_r.exl <= 1'b1;
            end else if (bus.eret_flush) begin
                status_r.exl <= 1'b0;
            end else if (wr_status_s) begin
                status_r.exl <= bus.write_data[1];
            end
        end
    end

    // Cause, EPC, BadVAddr and IP[7:2]; a nested exception (EXL=1) keeps EPC and BD.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cause_r    <= '0;
            epc_r      <= 32'd0;
            badvaddr_r <= 32'd0;
            ip_hw_r    <= 6'd0;
        end else begin
            ip_hw_r <= hw_irq_s;
            if (wr_cause_s) begin
                cause_r.dc    <= bus.write_data[27];
                cause_r.ip_sw <= bus.write_data[9:8];
            end
            if (bus.exception_valid) begin
                cause_r.exc_code <= bus.exception_code;
                if (bus.is_address_fault) begin
                    badvaddr_r <= bus.badvaddr_in;
                end
            end
            if (bus.exception_valid && !status_r.exl) begin
                cause_r.bd <= bus.in_delay_slot;
                epc_r      <= bus.in_delay_slot ? (bus.exception_address - 32'd4)
                                                : bus.exception_address;
            end else if (wr_epc_s) begin
                epc_r <= bus.write_data;
            end
        end
    end

    // Interrupt request to IF, squashed the cycle after an exception commits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            int_valid_r <= 1'b0;
        end else if (bus.exception_valid) begin
            int_valid_r <= 1'b0;
        end else begin
            int_valid_r <= (|({ip_hw_r, cause_r.ip_sw} & status_r.im)) & status_r.ie & ~status_r.exl;
        end
    end

    // mfc0 read mux: current register state, no bypass of same-cycle writes.
    always_comb begin
        read_data_s = 32'd0;
        if (sel0_s) begin
            case (bus.address_register)
                CP0_REG_BADVADDR: read_data_s = badvaddr_r;
                CP0_REG_COUNT:    read_data_s = count_s;
                CP0_REG_COMPARE:  read_data_s = compare_s;
                CP0_REG_STATUS:   read_data_s = status_word(status_r);
                CP0_REG_CAUSE:    read_data_s = cause_word(cause_r, ip_hw_r, ti_s);
                CP0_REG_EPC:      read_data_s = epc_r;
                CP0_REG_PRID:     read_data_s = PRID_VALUE;
                default:          read_data_s = 32'd0;
            endcase
        end else begin
            read_data_s = 32'd0;
        end
    end

    assign bus.read_data       = read_data_s;
    assign bus.epc_out         = epc_r;
    assign bus.interrupt_valid = int_valid_r;
    assign bus.timer_interrupt = ti_s;
endmodule

// File: tb/tb_coprocessor0_scalable.sv
module tb_coprocessor0_scalable;
    localparam int DIV   = 4;
    localparam int SYNC  = 2;
    localparam int TLINE = 5;

    logic clock = 1'b0;
    logic reset;
    logic check_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    coprocessor0_scalable_if #(.HW_INT_COUNT(6)) bus ();

    coprocessor0_scalable #(
        .HW_INT_COUNT(6), .COUNT_DIVIDE(DIV), .SYNC_STAGES(SYNC),
        .TIMER_IRQ_LINE(TLINE), .PRID_VALUE(32'h00004220)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    always #5 clock = ~clock;

    // Architectural reference state
    logic [31:0] m_badv = 32'd0, m_count = 32'd0, m_compare = 32'd0, m_epc = 32'd0;
    int          m_phase = 0;
    logic        m_ti = 1'b0, m_exl = 1'b0, m_ie = 1'b0, m_bd = 1'b0, m_dc = 1'b0, m_iv = 1'b0;
    logic [7:0]  m_im = 8'd0;
    logic [1:0]  m_ipsw = 2'd0;
    logic [5:0]  m_iphw = 6'd0;
    logic [4:0]  m_exc = 5'd0;
    logic [5:0]  hw_pipe[$];

    task automatic model_reset();
        m_badv = 32'd0; m_count = 32'd0; m_compare = 32'd0; m_epc = 32'd0; m_phase = 0;
        m_ti = 1'b0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_dc = 1'b0; m_iv = 1'b0;
        m_im = 8'd0; m_ipsw = 2'd0; m_iphw = 6'd0; m_exc = 5'd0;
        hw_pipe.delete();
        for (int i = 0; i < SYNC; i++) hw_pipe.push_back(6'd0);
    endtask

    task automatic model_step();
        logic        wr;
        logic [4:0]  r;
        logic [31:0] d, n_count;
        int          n_phase;
        logic        inc, n_ti;
        logic [5:0]  hw_old;
        wr = bus.write_enabled && (bus.address_select == 3'd0);
        r  = bus.address_register;
        d  = bus.write_data;
        inc = 1'b0; n_count = m_count; n_phase = m_phase;
        if (wr && r == 5'd9) begin
            n_count = d; n_phase = 0;
        end else if (!m_dc) begin
            if (m_phase == DIV - 1) begin
                n_phase = 0; n_count = m_count + 32'd1; inc = 1'b1;
            end else begin
                n_phase = m_phase + 1;
            end
        end
        n_ti = m_ti;
        if (wr && r == 5'd11) n_ti = 1'b0;
        else if (inc && n_count == m_compare) n_ti = 1'b1;
        m_iv = bus.exception_valid ? 1'b0
             : ((|({m_iphw, m_ipsw} & m_im)) && m_ie && !m_exl);
        hw_old = hw_pipe.pop_front();
        hw_pipe.push_back(bus.hardware_interrupt);
        m_iphw = hw_old | ({5'd0, m_ti} << TLINE);
        if (bus.exception_valid) begin
            m_exc = bus.exception_code;
            if (bus.is_address_fault) m_badv = bus.badvaddr_in;
        end
        if (bus.exception_valid && !m_exl) begin
            m_bd  = bus.in_delay_slot;
            m_epc = bus.in_delay_slot ? bus.exception_address - 32'd4 : bus.exception_address;
        end else if (wr && r == 5'd14) begin
            m_epc = d;
        end
        if (wr && r == 5'd12) begin m_im = d[15:8]; m_ie = d[0]; end
        if (wr && r == 5'd13) begin m_dc = d[27]; m_ipsw = d[9:8]; end
        if (wr && r == 5'd11) m_compare = d;
        if (bus.exception_valid) m_exl = 1'b1;
        else if (bus.eret_flush) m_exl = 1'b0;
        else if (wr && r == 5'd12) m_exl = d[1];
        m_count = n_count; m_phase = n_phase; m_ti = n_ti;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] r, input logic [2:0] s);
        if (s != 3'd0) return 32'd0;
        case (r)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
            5'd13:   return {m_bd, m_ti, 2'b00, m_dc, 11'd0, m_iphw, m_ipsw, 1'b0, m_exc, 2'b00};
            5'd14:   return m_epc;
            5'd15:   return 32'h00004220;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference model
    always @(negedge clock) begin
        if (check_en) begin
            check("read_data", bus.read_data, model_read(bus.address_register, bus.address_select));
            check("epc_out", bus.epc_out, m_epc);
            check("interrupt_valid", 32'(bus.interrupt_valid), 32'(m_iv));
            check("timer_interrupt", 32'(bus.timer_interrupt), 32'(m_ti));
        end
    end

    task automatic next();
        @(negedge clock);
        #2;
    endtask

    task automatic chk_reg(input string name, input logic [4:0] r, input logic [31:0] exp);
        bus.address_register = r;
        bus.address_select   = 3'd0;
        #1;
        check(name, bus.read_data, exp);
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        bus.write_enabled = 1'b1; bus.address_register = r; bus.address_select = 3'd0;
        bus.write_data = d;
        next();
        bus.write_enabled = 1'b0;
    endtask

    task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                             input logic fault, input logic [31:0] bad);
        bus.exception_valid = 1'b1; bus.exception_code = code; bus.exception_address = pc;
        bus.in_delay_slot = ds; bus.is_address_fault = fault; bus.badvaddr_in = bad;
        next();
        bus.exception_valid = 1'b0; bus.is_address_fault = 1'b0;
    endtask

    task automatic eret();
        bus.eret_flush = 1'b1;
        next();
        bus.eret_flush = 1'b0;
    endtask

    int regs[10] = '{8, 9, 10, 11, 12, 13, 14, 15, 0, 3};
    logic found;

    initial begin
        model_reset();
        reset = 1'b1;
        bus.write_enabled = 1'b0; bus.address_register = 5'd12; bus.address_select = 3'd0;
        bus.write_data = 32'd0; bus.exception_valid = 1'b0; bus.exception_code = 5'd0;
        bus.is_address_fault = 1'b0; bus.badvaddr_in = 32'd0; bus.exception_address = 32'd0;
        bus.in_delay_slot = 1'b0; bus.eret_flush = 1'b0; bus.hardware_interrupt = 6'd0;
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b0;
        check_en = 1'b1;

        // Reset state
        check("rst_epc", bus.epc_out, 32'd0);
        check("rst_iv", 32'(bus.interrupt_valid), 32'd0);
        chk_reg("rst_status", 5'd12, 32'h00400000);
        chk_reg("rst_prid", 5'd15, 32'h00004220);

        // Prescaler and wrap
        mtc0(5'd9, 32'hFFFFFFFE);
        chk_reg("cnt_written", 5'd9, 32'hFFFFFFFE);
        repeat (4) next();
        chk_reg("cnt_after4", 5'd9, 32'hFFFFFFFF);
        repeat (4) next();
        chk_reg("cnt_wrap", 5'd9, 32'h00000000);
        mtc0(5'd13, 32'h08000000);
        repeat (20) next();
        chk_reg("cnt_frozen", 5'd9, 32'h00000000);
        mtc0(5'd13, 32'h00000000);

        // Timer edge
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        found = 1'b0;
        bus.address_register = 5'd9;
        for (int i = 0; i < 100 && !found; i++) begin
            #1;
            if (bus.read_data == 32'd10) found = 1'b1;
            else next();
        end
        check("timer_reached", 32'(found), 32'd1);
        check("ti_at_match", 32'(bus.timer_interrupt), 32'd1);
        next();
        chk_reg("cause_ti_ip7", 5'd13, 32'h40008000);
        mtc0(5'd11, 32'd100);
        check("ti_cleared", 32'(bus.timer_interrupt), 32'd0);
        mtc0(5'd13, 32'h08000000);
        mtc0(5'd9, 32'd50);
        mtc0(5'd11, 32'd50);
        repeat (20) next();
        check("ti_frozen", 32'(bus.timer_interrupt), 32'd0);
        chk_reg("cnt_frozen50", 5'd9, 32'd50);
        mtc0(5'd13, 32'h00000000);
        mtc0(5'd11, 32'h80000000);

        // Nested exception
        raise_exc(5'd4, 32'h00000100, 1'b1, 1'b0, 32'd0);
        check("epc_ds", bus.epc_out, 32'h000000FC);
        chk_reg("cause_exc1", 5'd13, 32'h80000010);
        chk_reg("status_exl", 5'd12, 32'h00400002);
        raise_exc(5'd12, 32'h00000200, 1'b0, 1'b1, 32'hDEADBEEF);
        check("epc_held", bus.epc_out, 32'h000000FC);
        chk_reg("cause_exc2", 5'd13, 32'h80000030);
        chk_reg("badvaddr", 5'd8, 32'hDEADBEEF);
        eret();
        chk_reg("status_eret", 5'd12, 32'h00400000);

        // Interrupt path
        mtc0(5'd12, 32'h00000401);
        bus.hardware_interrupt = 6'b000001;
        for (int k = 1; k <= SYNC + 2; k++) begin
            next();
            check("iv_latency", 32'(bus.interrupt_valid), (k == SYNC + 2) ? 32'd1 : 32'd0);
        end
        raise_exc(5'd0, 32'h00000300, 1'b0, 1'b0, 32'd0);
        check("iv_after_exc", 32'(bus.interrupt_valid), 32'd0);
        check("epc_irq", bus.epc_out, 32'h00000300);
        repeat (3) next();
        check("iv_exl", 32'(bus.interrupt_valid), 32'd0);
        eret();
        check("iv_eret_lag", 32'(bus.interrupt_valid), 32'd0);
        next();
        check("iv_back", 32'(bus.interrupt_valid), 32'd1);
        bus.hardware_interrupt = 6'd0;
        repeat (5) next();
        check("iv_drop", 32'(bus.interrupt_valid), 32'd0);

        // Collisions
        bus.write_enabled = 1'b1; bus.address_register = 5'd12; bus.write_data = 32'd0;
        raise_exc(5'd8, 32'h00000400, 1'b0, 1'b0, 32'd0);
        bus.write_enabled = 1'b0;
        chk_reg("exl_collision", 5'd12, 32'h00400002);
        eret();
        mtc0(5'd9, 32'h00001000);
        repeat (3) next();
        mtc0(5'd9, 32'h00002000);
        chk_reg("cnt_write_wins", 5'd9, 32'h00002000);
        repeat (4) next();
        chk_reg("cnt_after_collide", 5'd9, 32'h00002001);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] r;
            r = 5'(regs[$urandom_range(0, 9)]);
            bus.write_enabled    = ($urandom_range(0, 3) == 0);
            bus.address_register = r;
            bus.address_select   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            case (r)
                5'd9:    bus.write_data = ($urandom_range(0, 3) == 0)
                                          ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                          : 32'($urandom_range(0, 40));
                5'd11:   bus.write_data = m_count + 32'($urandom_range(0, 6));
                5'd13: begin
                    bus.write_data     = $urandom;
                    bus.write_data[27] = ($urandom_range(0, 3) == 0);
                end
                default: bus.write_data = $urandom;
            endcase
            bus.exception_valid   = ($urandom_range(0, 15) == 0);
            bus.exception_code    = 5'($urandom);
            bus.exception_address = {$urandom, 2'b00} >> 2 << 2;
            bus.in_delay_slot     = 1'($urandom);
            bus.is_address_fault  = 1'($urandom);
            bus.badvaddr_in       = $urandom;
            bus.eret_flush        = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) bus.hardware_interrupt = 6'($urandom);
            next();
        end
        bus.write_enabled = 1'b0; bus.exception_valid = 1'b0; bus.eret_flush = 1'b0;
        bus.address_select = 3'd0; bus.address_register = 5'd12;
        next();

        // Asynchronous reset between edges
        #1;
        reset = 1'b1;
        #1;
        check("arst_epc", bus.epc_out, 32'd0);
        check("arst_iv", 32'(bus.interrupt_valid), 32'd0);
        check("arst_ti", 32'(bus.timer_interrupt), 32'd0);
        check("arst_status", bus.read_data, 32'h00400000);
        next();
        reset = 1'b0;
        repeat (10) next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
